// File: rtl/rel_tmr_hs_receiver.sv
// Receiving end of a TMR valid/ready stream: votes the replicated valid, holds one beat in a
// triplicated-control output register and excludes lanes that persistently disagree with the vote.
module rel_tmr_hs_receiver #(
  parameter type         T              = logic,
  parameter int unsigned FaultThreshold = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [2:0] valid_i,
  output logic [2:0] ready_o,
  input  T           data_i,
  output logic       valid_o,
  input  logic       ready_i,
  output T           data_o,
  input  logic       clear_i,
  output logic [2:0] lane_bad_o,
  output logic       fault_o
);

  localparam int unsigned CntWidth = $clog2(FaultThreshold + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(FaultThreshold);

  logic [2:0] full_q, full_d;
  T           data_q;
  logic       full_v, rdy_v, load;

  logic [2:0] lane_bad_q, lane_bad_d;
  logic [2:0] good, mismatch;
  logic       vvalid, single_good;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // Valid vote: full majority with three lanes, otherwise AND of the surviving lanes so a
  // split between two lanes never produces a spurious beat.
  always_comb begin
    good        = ~lane_bad_q;
    single_good = $onehot(good);
    if (good == 3'b111) vvalid = maj3(valid_i);
    else                vvalid = (|good) & (&(valid_i | lane_bad_q));
  end

  assign full_v = maj3(full_q);
  assign rdy_v  = !full_v || ready_i;
  assign load   = vvalid && rdy_v;

  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                bad_d;

    assign ready_o[gi]  = !full_v || ready_i;
    // Each replica is rebuilt from the voted value, so a single upset heals in one cycle.
    assign full_d[gi]   = load ? 1'b1 : ((full_v && ready_i) ? 1'b0 : full_v);
    assign mismatch[gi] = good[gi] && (valid_i[gi] != vvalid);

    always_comb begin
      cnt_d = '0;
      bad_d = lane_bad_q[gi];
      if (clear_i) begin
        bad_d = 1'b0;
      end else if (mismatch[gi] && !single_good) begin
        cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
        if (cnt_d == CntMax) bad_d = 1'b1;
      end
    end

    assign lane_bad_d[gi] = bad_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q     <= 3'b000;
      data_q     <= '0;
      lane_bad_q <= 3'b000;
    end else begin
      full_q     <= full_d;
      lane_bad_q <= lane_bad_d;
      if (load) data_q <= data_i;
    end
  end

  assign valid_o    = full_v;
  assign data_o     = data_q;
  assign lane_bad_o = lane_bad_q;
  assign fault_o    = (|mismatch) || !((&full_q) || !(|full_q));

endmodule
